// File: rtl/argmax_l2_if.sv
// Handshake and data bundle between the layer-2 MAC array,
// the argmax classifier and its consumer.
interface argmax_l2_if #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 20,
  parameter int IDX_W       = 4
);

  logic                         start;
  logic                         abort;
  logic [NUM_CLASSES*ACC_W-1:0] acc_in_packed;
  logic                         busy;
  logic                         done;
  logic                         valid;
  logic [IDX_W-1:0]             class_idx;
  logic [ACC_W-1:0]             max_val;

  modport master (
    output start,
    output abort,
    output acc_in_packed,
    input  busy,
    input  done,
    input  valid,
    input  class_idx,
    input  max_val
  );

  modport slave (
    input  start,
    input  abort,
    input  acc_in_packed,
    output busy,
    output done,
    output valid,
    output class_idx,
    output max_val
  );

endinterface

// File: rtl/argmax_l2.sv
// Snapshots the 10-lane layer-2 accumulator vector and scans it one
// lane per cycle, reporting the index and value of the largest logit.
module argmax_l2 #(
  parameter int NUM_CLASSES = 10,
  parameter int ACC_W       = 20,
  parameter int IDX_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  argmax_l2_if.slave  bus
);

  localparam int VEC_W = NUM_CLASSES * ACC_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [VEC_W-1:0]         snap_q, snap_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic signed [ACC_W-1:0]  best_val_q, best_val_d;
  logic [IDX_W-1:0]         best_idx_q, best_idx_d;
  logic [IDX_W-1:0]         class_idx_q, class_idx_d;
  logic [ACC_W-1:0]         max_val_q, max_val_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     valid_q, valid_d;

  logic signed [ACC_W-1:0]  cur;
  logic                     gt;
  logic signed [ACC_W-1:0]  nxt_val;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     load;

  always_comb begin
    cur = '0;
    for (int j = 0; j < NUM_CLASSES; j++) begin
      if (ptr_q == IDX_W'(j)) begin
        cur = snap_q[j*ACC_W +: ACC_W];
      end
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  assign gt      = cur > best_val_q;
  assign nxt_val = gt ? cur : best_val_q;
  assign nxt_idx = gt ? ptr_q : best_idx_q;

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    valid_d     = valid_q;
    load        = 1'b0;

    if (bus.abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          load = bus.start;
        end
        SCAN: begin
          best_val_d = nxt_val;
          best_idx_d = nxt_idx;
          ptr_d      = ptr_q + 1'b1;
          if (ptr_q == LAST) begin
            state_d     = DONE;
            class_idx_d = nxt_idx;
            max_val_d   = nxt_val;
            done_d      = 1'b1;
            valid_d     = 1'b1;
          end
        end
        DONE: begin
          // The DONE->IDLE edge may also start the next image.
          state_d = IDLE;
          busy_d  = 1'b0;
          load    = bus.start;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (load) begin
      state_d    = SCAN;
      snap_d     = bus.acc_in_packed;
      best_val_d = bus.acc_in_packed[ACC_W-1:0];
      best_idx_d = '0;
      ptr_d      = IDX_W'(1);
      busy_d     = 1'b1;
      valid_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      ptr_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.valid     = valid_q;
  assign bus.class_idx = class_idx_q;
  assign bus.max_val   = max_val_q;

endmodule

// File: tb/tb_argmax_l2.sv
// Directed bench for argmax_l2: vector table of scans plus
// hand-written sequences for start-while-busy, abort and async reset.
module tb_argmax_l2;

  logic clk;
  logic rst;

  argmax_l2_if bus ();

  argmax_l2 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nerr;

  typedef struct {
    string                   name;
    logic [199:0]            vec;
    logic [3:0]              idx;
    logic signed [19:0]      val;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] fill(input int x);
    logic [199:0] r;
    logic [31:0]  t;
    t = x;
    for (int j = 0; j < 10; j++) r[j*20 +: 20] = t[19:0];
    return r;
  endfunction

  function automatic logic [199:0] set_lane(input logic [199:0] v,
                                            input int j, input int x);
    logic [199:0] r;
    logic [31:0]  t;
    r = v;
    t = x;
    r[j*20 +: 20] = t[19:0];
    return r;
  endfunction

  // Starts a scan at the next edge (E0) and checks the whole result window.
  task automatic run_vec(input string nm, input logic [199:0] v,
                         input logic [3:0] eidx,
                         input logic signed [19:0] eval);
    int n;
    bus.start = 1'b1;
    bus.acc_in_packed = v;
    cyc();
    bus.start = 1'b0;
    chk({nm, ".busy_e0"}, 32'(bus.busy), 1);
    chk({nm, ".valid_clr"}, 32'(bus.valid), 0);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    chk({nm, ".latency"}, n, 9);
    chk({nm, ".idx"}, 32'(bus.class_idx), 32'(eidx));
    chk({nm, ".val"}, $signed(bus.max_val), eval);
    chk({nm, ".valid"}, 32'(bus.valid), 1);
    cyc();
    chk({nm, ".done_pulse"}, 32'(bus.done), 0);
    chk({nm, ".busy_e10"}, 32'(bus.busy), 0);
    chk({nm, ".valid_sticky"}, 32'(bus.valid), 1);
  endtask

  logic [199:0] v_dist, v_tie, v_min, v_neg;
  int ndone;
  int got_idx [2];
  int got_val [2];
  int done_at [2];

  initial begin
    nchk = 0;
    nerr = 0;

    v_dist = fill(0);
    v_dist = set_lane(v_dist, 0, 5);
    v_dist = set_lane(v_dist, 1, -3);
    v_dist = set_lane(v_dist, 2, 12);
    v_dist = set_lane(v_dist, 3, 0);
    v_dist = set_lane(v_dist, 4, 7);
    v_dist = set_lane(v_dist, 5, 1);
    v_dist = set_lane(v_dist, 6, 2);
    v_dist = set_lane(v_dist, 7, 900);
    v_dist = set_lane(v_dist, 8, -900);
    v_dist = set_lane(v_dist, 9, 899);

    v_min = fill(-524288);
    v_tie = set_lane(v_min, 2, 524287);
    v_tie = set_lane(v_tie, 5, 524287);

    v_neg = fill(0);
    for (int j = 0; j < 10; j++) v_neg = set_lane(v_neg, j, -100 + j*10);

    tbl[0] = '{"distinct", v_dist, 4'd7, 20'sd900};
    tbl[1] = '{"tie_max",  v_tie,  4'd2, 20'sd524287};
    tbl[2] = '{"all_min",  v_min,  4'd0, -20'sd524288};
    tbl[3] = '{"all_neg",  v_neg,  4'd9, -20'sd10};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.acc_in_packed = '0;
    rst = 1'b0;
    #12;
    chk("rst.busy",  32'(bus.busy), 0);
    chk("rst.done",  32'(bus.done), 0);
    chk("rst.valid", 32'(bus.valid), 0);
    chk("rst.idx",   32'(bus.class_idx), 0);
    chk("rst.val",   $signed(bus.max_val), 0);
    rst = 1'b1;
    cyc();
    cyc();

    for (int i = 0; i < 4; i++) begin
      run_vec(tbl[i].name, tbl[i].vec, tbl[i].idx, tbl[i].val);
      cyc();
    end

    // Input changes after the snapshot must not disturb the result.
    bus.start = 1'b1;
    bus.acc_in_packed = v_neg;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    bus.acc_in_packed = fill(1000);
    for (int k = 0; k < 7; k++) cyc();
    chk("snap.done", 32'(bus.done), 1);
    chk("snap.idx",  32'(bus.class_idx), 9);
    chk("snap.val",  $signed(bus.max_val), -10);
    cyc();
    cyc();

    // start at E4 ignored, start at E10 accepted back-to-back.
    ndone = 0;
    bus.start = 1'b1;
    bus.acc_in_packed = v_dist;
    cyc();
    for (int k = 1; k <= 25; k++) begin
      bus.start = (k == 4 || k == 10);
      bus.acc_in_packed = (k == 4) ? v_tie : (k == 10) ? v_neg : v_dist;
      cyc();
      if (bus.done === 1'b1) begin
        if (ndone < 2) begin
          got_idx[ndone] = int'(bus.class_idx);
          got_val[ndone] = int'($signed(bus.max_val));
          done_at[ndone] = k;
        end
        ndone++;
      end
    end
    bus.start = 1'b0;
    chk("b2b.count", ndone, 2);
    if (ndone >= 2) begin
      chk("b2b.idx0", got_idx[0], 7);
      chk("b2b.val0", got_val[0], 900);
      chk("b2b.at0",  done_at[0], 9);
      chk("b2b.idx1", got_idx[1], 9);
      chk("b2b.val1", got_val[1], -10);
      chk("b2b.at1",  done_at[1], 19);
    end

    // Abort at E5 after a scan that left class_idx=9.
    bus.start = 1'b1;
    bus.acc_in_packed = v_dist;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    chk("abort.busy",  32'(bus.busy), 0);
    chk("abort.valid", 32'(bus.valid), 0);
    chk("abort.done",  32'(bus.done), 0);
    chk("abort.idx",   32'(bus.class_idx), 9);
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort.no_done", ndone, 0);
    run_vec("post_abort", v_tie, 4'd2, 20'sd524287);
    cyc();

    // Asynchronous reset between E3 and E4.
    bus.start = 1'b1;
    bus.acc_in_packed = v_dist;
    cyc();
    bus.start = 1'b0;
    for (int k = 1; k <= 3; k++) cyc();
    #2;
    rst = 1'b0;
    #1;
    chk("arst.busy",  32'(bus.busy), 0);
    chk("arst.done",  32'(bus.done), 0);
    chk("arst.valid", 32'(bus.valid), 0);
    chk("arst.idx",   32'(bus.class_idx), 0);
    chk("arst.val",   $signed(bus.max_val), 0);
    #2;
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (bus.done === 1'b1) ndone++;
    end
    chk("arst.no_done", ndone, 0);
    run_vec("post_rst", v_dist, 4'd7, 20'sd900);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
